// File: rtl/noc_req_arbiter.sv
// Round-robin injection arbiter: one request slot per ant, per-ant credit limit, single NoC request port.
// Optional NOC_ARB_STALL_CNT_EN adds a saturating backpressure stall counter output.
module noc_req_arbiter #(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [23:0] req_page,
    output logic [3:0]  req_ready,
    output logic        pkt_valid,
    output logic [11:0] pkt_data,
    input  logic        pkt_ready,
    input  logic        resp_valid,
    input  logic [1:0]  resp_src,
    output logic        err_ovf
`ifdef NOC_ARB_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned PAGE_W = 6;
    localparam int unsigned REQ_W  = 12;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned IDX_W  = 2;
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

    typedef enum logic {
        OST_IDLE,
        OST_VALID
    } ost_e;

    ost_e              ost_q, ost_d;
    logic [N_REQ-1:0]  slot_full_q, slot_full_d;
    logic [PAGE_W-1:0] slot_page_q [N_REQ];
    logic [CNT_W-1:0]  out_cnt_q [N_REQ];
    logic [CNT_W-1:0]  out_cnt_d [N_REQ];
    logic [IDX_W-1:0]  rr_q, rr_d, win;
    logic [N_REQ-1:0]  accept, grant, eligible, ret;
    logic              found;
    logic              ovf_c;
    logic [REQ_W-1:0]  pkt_data_d;

    assign pkt_valid = (ost_q == OST_VALID);

    // A slot competes only while it holds a request and its ant has credit left
    always_comb begin
        accept   = req_valid & req_ready;
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = slot_full_q[i] && (out_cnt_q[i] < MAX_OUT_C);
        end
    end

    // Output stage: re-arbitrate when empty or when the held packet is taken
    always_comb begin
        ost_d      = ost_q;
        rr_d       = rr_q;
        pkt_data_d = pkt_data;
        grant      = '0;
        win        = '0;
        found      = 1'b0;
        if (ost_q == OST_IDLE || pkt_ready) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && eligible[IDX_W'(rr_q + IDX_W'(k))]) begin
                    found = 1'b1;
                    win   = IDX_W'(rr_q + IDX_W'(k));
                end
            end
            if (found) begin
                grant[win] = 1'b1;
                pkt_data_d = {2'b00, win, slot_page_q[win][PAGE_W-1 -: 2], slot_page_q[win]};
                ost_d      = OST_VALID;
                rr_d       = IDX_W'(win + 2'd1);
            end else begin
                ost_d = OST_IDLE;
            end
        end
    end

    // Slot occupancy and credit bookkeeping; a return against zero outstanding is dropped
    always_comb begin
        slot_full_d = (slot_full_q & ~grant) | accept;
        ovf_c       = resp_valid && (out_cnt_q[resp_src] == '0);
        ret         = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ret[i]       = resp_valid && (resp_src == IDX_W'(i)) && (out_cnt_q[i] != '0);
            out_cnt_d[i] = out_cnt_q[i] + CNT_W'(grant[i]) - CNT_W'(ret[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ost_q       <= OST_IDLE;
            rr_q        <= '0;
            pkt_data    <= '0;
            slot_full_q <= '0;
            req_ready   <= '0;
            err_ovf     <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                out_cnt_q[i]   <= '0;
                slot_page_q[i] <= '0;
            end
        end else begin
            ost_q       <= ost_d;
            rr_q        <= rr_d;
            pkt_data    <= pkt_data_d;
            slot_full_q <= slot_full_d;
            req_ready   <= ~slot_full_d;
            err_ovf     <= err_ovf | ovf_c;
            for (int i = 0; i < N_REQ; i++) begin
                out_cnt_q[i] <= out_cnt_d[i];
                if (accept[i]) begin
                    slot_page_q[i] <= req_page[PAGE_W*i +: PAGE_W];
                end
            end
        end
    end

`ifdef NOC_ARB_STALL_CNT_EN
    // Saturating count of cycles the router holds off a valid packet
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (pkt_valid && !pkt_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_req_arbiter.sv
// Bench for noc_req_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_noc_req_arbiter;

    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [23:0] req_page;
    logic [3:0]  req_ready;
    logic        pkt_valid;
    logic [11:0] pkt_data;
    logic        pkt_ready;
    logic        resp_valid;
    logic [1:0]  resp_src;
    logic        err_ovf;
`ifdef NOC_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_full[4], m_page[4], m_cnt[4], m_ready[4];
    int m_rr, m_pv, m_pd, m_err, m_stall;
    int dut_grants[4];

    noc_req_arbiter #(.MAX_OUT(MAX_OUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_page   (req_page),
        .req_ready  (req_ready),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .pkt_ready  (pkt_ready),
        .resp_valid (resp_valid),
        .resp_src   (resp_src),
        .err_ovf    (err_ovf)
`ifdef NOC_ARB_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Accepted packets per source, observed mid-cycle when handshake inputs are stable
    always @(negedge clk) begin
        if (reset === 1'b1 && pkt_valid === 1'b1 && pkt_ready === 1'b1)
            dut_grants[pkt_data[9:8]]++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_ready_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (m_ready[i] != 0);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 0; m_page[i] = 0; m_cnt[i] = 0; m_ready[i] = 0; dut_grants[i] = 0;
        end
        m_rr = 0; m_pv = 0; m_pd = 0; m_err = 0; m_stall = 0;
    endtask

    // One rising edge of the specified behaviour, using the inputs currently driven
    task automatic model_step();
        int win;
        win = -1;
        if (m_pv != 0 && !pkt_ready && m_stall < 65535) m_stall++;
        if (m_pv == 0 || pkt_ready) begin
            for (int k = 0; k < 4; k++) begin
                int a;
                a = (m_rr + k) % 4;
                if (win < 0 && m_full[a] != 0 && m_cnt[a] < MAX_OUT) win = a;
            end
            if (win >= 0) begin
                m_pd = win * 256 + (m_page[win] / 16) * 64 + m_page[win];
                m_pv = 1;
                m_rr = (win + 1) % 4;
            end else begin
                m_pv = 0;
            end
        end
        if (resp_valid && m_cnt[resp_src] == 0) m_err = 1;
        for (int i = 0; i < 4; i++) begin
            int dec;
            dec = (resp_valid && resp_src == i && m_cnt[i] > 0) ? 1 : 0;
            m_cnt[i] = m_cnt[i] + ((i == win) ? 1 : 0) - dec;
        end
        for (int i = 0; i < 4; i++) begin
            if (i == win) m_full[i] = 0;
            if (req_valid[i] && m_ready[i] != 0) begin
                m_full[i] = 1;
                m_page[i] = int'(req_page[6*i +: 6]);
            end
        end
        for (int i = 0; i < 4; i++) m_ready[i] = (m_full[i] == 0) ? 1 : 0;
    endtask

    task automatic compare_all();
        check_eq("req_ready", 32'(req_ready), 32'(m_ready_vec()));
        check_eq("pkt_valid", 32'(pkt_valid), 32'(m_pv));
        check_eq("pkt_data", 32'(pkt_data), 32'(m_pd));
        check_eq("err_ovf", 32'(err_ovf), 32'(m_err));
`ifdef NOC_ARB_STALL_CNT_EN
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases on the falling edge
    task automatic do_reset();
        req_valid  = '0;
        resp_valid = 1'b0;
        resp_src   = '0;
        reset      = 1'b0;
        #1;
        check_eq("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_pkt_data", 32'(pkt_data), 32'd0);
        check_eq("rst_err_ovf", 32'(err_ovf), 32'd0);
`ifdef NOC_ARB_STALL_CNT_EN
        check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [11:0] held;

    initial begin
        reset      = 1'b0;
        req_valid  = '0;
        req_page   = '0;
        pkt_ready  = 1'b1;
        resp_valid = 1'b0;
        resp_src   = '0;
        #2;
        do_reset();

        // Reset release and idle
        cycle();
        check_eq("ready_after_rst", 32'(req_ready), 32'hF);
        cycle();

        // Single request: ant0 page 60
        req_valid = 4'b0001;
        req_page  = 24'd60;
        cycle();
        req_valid = '0;
        check_eq("single_t1_valid", 32'(pkt_valid), 32'd0);
        cycle();
        check_eq("single_t2_valid", 32'(pkt_valid), 32'd1);
        check_eq("single_t2_data", 32'(pkt_data), 32'h0FC);
        repeat (3) cycle();

        // All four ants at once from rr_ptr=0
        do_reset();
        cycle();
        req_valid = 4'hF;
        req_page  = 24'($urandom);
        cycle();
        req_valid = '0;
        cycle();
        for (int k = 0; k < 4; k++) begin
            check_eq("all4_src", 32'(pkt_data[9:8]), 32'(k));
            check_eq("all4_valid", 32'(pkt_valid), 32'd1);
            cycle();
        end
        check_eq("all4_drained", 32'(pkt_valid), 32'd0);
        cycle();

        // Backpressure: held packet stays stable, no further grants
        pkt_ready = 1'b0;
        req_valid = 4'hF;
        req_page  = 24'($urandom);
        cycle();
        req_valid = '0;
        cycle();
        held = pkt_data;
        check_eq("bp_valid", 32'(pkt_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_eq("bp_hold_data", 32'(pkt_data), 32'(held));
            check_eq("bp_hold_ready", 32'(req_ready), 32'h1);
        end
`ifdef NOC_ARB_STALL_CNT_EN
        check_eq("bp_stall_cnt", 32'(stall_cnt), 32'd5);
`endif
        // Reset while a packet is held
        pkt_ready = 1'b1;
        do_reset();
        cycle();

        // Credit limit on ant2
        req_valid = 4'b0100;
        req_page  = 24'h00_0000 | (24'd37 << 12);
        repeat (20) cycle();
        check_eq("credit_grants", 32'(dut_grants[2]), 32'd4);
        check_eq("credit_slot_full", 32'(req_ready[2]), 32'd0);
        req_valid  = '0;
        resp_valid = 1'b1;
        resp_src   = 2'd2;
        cycle();
        resp_valid = 1'b0;
        cycle();
        check_eq("credit_ret_valid", 32'(pkt_valid), 32'd1);
        check_eq("credit_ret_src", 32'(pkt_data[9:8]), 32'd2);
        repeat (3) cycle();

        // Credit return with nothing outstanding
        do_reset();
        cycle();
        resp_valid = 1'b1;
        resp_src   = 2'd1;
        cycle();
        resp_valid = 1'b0;
        check_eq("ovf_set", 32'(err_ovf), 32'd1);
        req_valid = 4'b0010;
        req_page  = 24'($urandom);
        repeat (20) cycle();
        check_eq("ovf_sticky", 32'(err_ovf), 32'd1);
        check_eq("ovf_no_wrap_grants", 32'(dut_grants[1]), 32'd4);

        // Random traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            req_valid  = 4'($urandom);
            req_page   = 24'($urandom);
            pkt_ready  = ($urandom % 4) != 0;
            resp_valid = ($urandom % 3) == 0;
            resp_src   = 2'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
